// File: rtl/hwpe_stream_split_buffered.sv
// hwpe_stream_split_buffered
//   Splits one wide stream beat into NB_OUT_STREAMS narrow slices. Lane ii carries
//   bits [(ii+1)*DATA_WIDTH_OUT-1 : ii*DATA_WIDTH_OUT] of the input beat. Each beat
//   is held in a one-deep buffer. Every lane hands over its slice on its own
//   handshake, so the consumers do not need to be ready in the same cycle.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear; drops any buffered beat
//   push_*          wide sink stream (valid/ready/data/strb)
//   pop_*           NB_OUT_STREAMS narrow source streams, packed [lane][bits]
module hwpe_stream_split_buffered #(
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned DATA_WIDTH_OUT = 32
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              clear_i,
    input  logic                                              push_valid_i,
    output logic                                              push_ready_o,
    input  logic [NB_OUT_STREAMS*DATA_WIDTH_OUT-1:0]          push_data_i,
    input  logic [NB_OUT_STREAMS*DATA_WIDTH_OUT/8-1:0]        push_strb_i,
    output logic [NB_OUT_STREAMS-1:0]                         pop_valid_o,
    input  logic [NB_OUT_STREAMS-1:0]                         pop_ready_i,
    output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT-1:0]     pop_data_o,
    output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT/8-1:0]   pop_strb_o
);

    localparam int unsigned STRB_OUT = DATA_WIDTH_OUT / 8;

    logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT-1:0] data_q;
    logic [NB_OUT_STREAMS-1:0][STRB_OUT-1:0]       strb_q;
    logic [NB_OUT_STREAMS-1:0]                     pending_q;
    logic [NB_OUT_STREAMS-1:0]                     done;
    logic                                          accept;

    // A new beat may enter when every still-pending lane completes this cycle,
    // giving one wide beat per cycle when all consumers are ready. Clear wins
    // over an accept by forcing ready low.
    assign done         = pending_q & pop_ready_i;
    assign push_ready_o = ~clear_i & ~(|(pending_q & ~done));
    assign accept       = push_valid_i & push_ready_o;

    // The buffer loads as a whole; the packed [lane][bits] layout matches the
    // flat input bit order, so lane ii picks up slice ii directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            strb_q <= '0;
        end else if (accept) begin
            data_q <= push_data_i;
            strb_q <= push_strb_i;
        end
    end

    // Per-lane pending flag: a reload takes precedence over that lane's own
    // completion, so back-to-back beats never lose a slice.
    for (genvar ii = 0; ii < NB_OUT_STREAMS; ii++) begin : g_lane
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                pending_q[ii] <= 1'b0;
            else if (clear_i)
                pending_q[ii] <= 1'b0;
            else if (accept)
                pending_q[ii] <= 1'b1;
            else if (done[ii])
                pending_q[ii] <= 1'b0;
        end

        assign pop_valid_o[ii] = pending_q[ii];
        assign pop_data_o[ii]  = data_q[ii];
        assign pop_strb_o[ii]  = strb_q[ii];
    end

endmodule
